// File: rtl/osd_pkg.sv
// Shared types and constants for the OSD character-buffer write controller.
// 128-entry buffer of 6-bit character codes, addressed by a 7-bit pointer.
package osd_pkg;

  localparam int OSD_CHARS  = 128;
  localparam int OSD_ADDR_W = 7;
  localparam int OSD_CHAR_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    CLEAR
  } osd_ctrl_state_t;

  typedef struct packed {
    logic [OSD_ADDR_W-1:0] addr;
    logic [OSD_CHAR_W-1:0] data;
    logic                  last;
  } osd_msg_t;

  // Frame-timer width; a zero timeout still needs a 1-bit register.
  function automatic int timer_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/osd_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
// Purely combinational, zero latency; the last-grant state is held by the caller.
module osd_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |valid;
  assign grant_idx   = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/osd_ctrl.sv
// OSD character-buffer write controller: arbitrates two message streams, frame-timed auto-clear.
// Writes appear one cycle after each accepted beat; requesters see ready only while granted in XFER.
module osd_ctrl
  import osd_pkg::*;
#(
  parameter int                    TIMEOUT_FRAMES = 180,
  parameter logic [OSD_CHAR_W-1:0] BLANK_CHAR     = 6'd0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync_pulse,
  input  logic                  clear_req,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OSD_ADDR_W-1:0] req0_addr,
  input  logic [OSD_CHAR_W-1:0] req0_data,
  input  logic                  req0_last,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OSD_ADDR_W-1:0] req1_addr,
  input  logic [OSD_CHAR_W-1:0] req1_data,
  input  logic                  req1_last,
  output logic [OSD_CHAR_W-1:0] char_data,
  output logic                  char_we,
  output logic [OSD_ADDR_W-1:0] char_addr,
  output logic                  osd_enable,
  output logic                  busy
);

  localparam int                    TW           = timer_width(TIMEOUT_FRAMES);
  localparam logic [TW-1:0]         TIMER_RELOAD = TW'(TIMEOUT_FRAMES);
  localparam logic [OSD_ADDR_W-1:0] LAST_ADDR    = OSD_ADDR_W'(OSD_CHARS - 1);

  osd_ctrl_state_t       state;
  logic [OSD_ADDR_W-1:0] ptr;
  logic                  gnt_idx;
  logic                  last_grant;
  logic                  clear_pending;
  logic [TW-1:0]         timer;

  osd_msg_t msg [2];
  osd_msg_t cur_msg;
  logic     cur_valid;
  logic     arb_vld;
  logic     arb_idx;
  logic     beat;
  logic     msg_done;
  logic     clear_done;
  logic     timer_expire;

  assign msg[0] = '{addr: req0_addr, data: req0_data, last: req0_last};
  assign msg[1] = '{addr: req1_addr, data: req1_data, last: req1_last};

  assign cur_msg   = msg[gnt_idx];
  assign cur_valid = gnt_idx ? req1_valid : req0_valid;

  assign req0_ready = (state == XFER) && !gnt_idx;
  assign req1_ready = (state == XFER) &&  gnt_idx;
  assign busy       = (state != IDLE);

  assign beat         = (state == XFER) && cur_valid;
  assign msg_done     = beat && cur_msg.last;
  assign clear_done   = (state == CLEAR) && (ptr == LAST_ADDR);
  assign timer_expire = vsync_pulse && osd_enable && (timer == TW'(1));

  osd_rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .grant_valid (arb_vld),
    .grant_idx   (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      gnt_idx       <= 1'b0;
      last_grant    <= 1'b1;
      clear_pending <= 1'b0;
      timer         <= '0;
      char_we       <= 1'b0;
      char_data     <= '0;
      char_addr     <= '0;
      osd_enable    <= 1'b0;
    end else begin
      char_we <= 1'b0;

      case (state)
        IDLE: begin
          // A pending clear always beats a waiting message.
          if (clear_pending) begin
            ptr   <= '0;
            state <= CLEAR;
          end else if (arb_vld) begin
            gnt_idx <= arb_idx;
            ptr     <= msg[arb_idx].addr;
            state   <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            char_we   <= 1'b1;
            char_data <= cur_msg.data;
            char_addr <= ptr;
            ptr       <= ptr + 1'b1;
            if (cur_msg.last) begin
              last_grant <= gnt_idx;
              osd_enable <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        CLEAR: begin
          char_we   <= 1'b1;
          char_data <= BLANK_CHAR;
          char_addr <= ptr;
          ptr       <= ptr + 1'b1;
          if (clear_done) begin
            osd_enable <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A completing message reloads the timer even if this vsync would have expired it.
      if (msg_done) begin
        timer <= TIMER_RELOAD;
      end else if (clear_done) begin
        timer <= '0;
      end else if (vsync_pulse && osd_enable && (timer != '0)) begin
        timer <= timer - 1'b1;
      end

      if (clear_req || (timer_expire && !msg_done)) begin
        clear_pending <= 1'b1;
      end else if (clear_done) begin
        clear_pending <= 1'b0;
      end
    end
  end

endmodule
